fifo_feed_scheduler: RTL and testbench

Sequencer and 2-way arbiter for the free-running shift-register FIFO_buffer (SIZE, WIDTH) that carries operand rows into the compute pipeline. Two requesters each ask for a burst of rows from a shared operand buffer. The block grants one requester at a time by round-robin, issues buffer reads, and tags the data entering the FIFO as valid or bubble. It then waits for the burst to drain through the fixed-depth FIFO before signalling completion.

---
 rtl/fifo_feed_scheduler.sv | 147 ++++++++++++++
 tb/tb_fifo_feed_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_feed_scheduler.sv
// fifo_feed_scheduler
// Round-robin arbiter and read sequencer feeding a fixed-depth shift-register
// FIFO. A granted burst issues one buffer read per cycle and marks the
// matching FIFO input as valid one cycle later. The block then waits for the
// last row to leave the FIFO and reports completion.

module fifo_feed_scheduler #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] base0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              feed_valid,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  // Drain counter must hold the value SIZE.
  localparam int DW = $clog2(SIZE + 2);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic               rr, rr_next;
  logic               owner, owner_next;
  logic [LEN_W-1:0]   remain, remain_next;
  logic [DW-1:0]      drain_cnt, drain_cnt_next;
  logic [1:0]         ack_next;
  logic               rd_en_next;
  logic [ADDR_W-1:0]  rd_addr_next;
  logic               done_next;
  logic               done_id_next;
  logic               grant;
  logic [ADDR_W-1:0]  sel_base;
  logic [LEN_W-1:0]   sel_len;

  // Arbitration choice and sampled burst parameters of the winning requester.
  always_comb begin
    grant    = (req == 2'b11) ? rr : req[1];
    sel_base = grant ? base1 : base0;
    sel_len  = grant ? len1  : len0;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next     = state;
    rr_next        = rr;
    owner_next     = owner;
    remain_next    = remain;
    drain_cnt_next = drain_cnt;
    ack_next       = 2'b00;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr;
    done_next      = 1'b0;
    done_id_next   = done_id;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          owner_next = grant;
          rr_next    = ~grant;
          ack_next   = grant ? 2'b10 : 2'b01;
          if (sel_len == '0) begin
            state_next = DONE;
          end else begin
            state_next   = FEED;
            rd_en_next   = 1'b1;
            rd_addr_next = sel_base;
            remain_next  = sel_len - LEN_W'(1);
          end
        end
      end
      FEED: begin
        if (remain == '0) begin
          state_next     = DRAIN;
          drain_cnt_next = DW'(SIZE);
        end else begin
          rd_en_next   = 1'b1;
          rd_addr_next = rd_addr + ADDR_W'(1);
          remain_next  = remain - LEN_W'(1);
        end
      end
      DRAIN: begin
        // SIZE+1 cycles: the final valid FIFO input plus SIZE stages.
        if (drain_cnt == '0) begin
          state_next   = DONE;
          done_next    = 1'b1;
          done_id_next = owner;
        end else begin
          drain_cnt_next = drain_cnt - DW'(1);
        end
      end
      DONE: begin
        // A zero-length burst enters here with the ack cycle, so done is
        // raised one cycle later; otherwise done is already up and we leave.
        if (done) begin
          state_next = IDLE;
        end else begin
          done_next    = 1'b1;
          done_id_next = owner;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      owner      <= 1'b0;
      remain     <= '0;
      drain_cnt  <= '0;
      ack        <= 2'b00;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      state      <= state_next;
      rr         <= rr_next;
      owner      <= owner_next;
      remain     <= remain_next;
      drain_cnt  <= drain_cnt_next;
      ack        <= ack_next;
      rd_en      <= rd_en_next;
      rd_addr    <= rd_addr_next;
      feed_valid <= rd_en;
      busy       <= (state_next != IDLE);
      done       <= done_next;
      done_id    <= done_id_next;
    end
  end

endmodule

// File: tb/tb_fifo_feed_scheduler.sv
// tb_fifo_feed_scheduler
// Directed scenarios followed by randomized traffic. A schedule model turns
// each grant into the expected per-cycle output timeline of its burst.

module tb_fifo_feed_scheduler;

  localparam int SIZE = 4;
  localparam int N    = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] base0, len0, base1, len1;
  logic [1:0] ack;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       feed_valid, busy, done, done_id;

  fifo_feed_scheduler #(.SIZE(SIZE), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .base0(base0), .len0(len0), .base1(base1), .len1(len1),
    .ack(ack), .rd_en(rd_en), .rd_addr(rd_addr), .feed_valid(feed_valid),
    .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  // Expected per-cycle timeline.
  logic [1:0] exp_ack  [N];
  logic       exp_rden [N];
  logic [7:0] exp_addr [N];
  logic       exp_fv   [N];
  logic       exp_busy [N];
  logic       exp_done [N];
  logic       exp_did  [N];

  int   cyc = 0;
  int   idle_from = 0;
  bit   rr = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, want);
    end
  endtask

  task automatic clear_from(input int s);
    for (int i = s; i < N; i++) begin
      exp_ack[i] = 2'b00; exp_rden[i] = 1'b0; exp_addr[i] = 8'h00;
      exp_fv[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_did[i] = 1'b0;
    end
  endtask

  // Burst schedule: ack at cycle a, reads a..a+len-1, valid one cycle later,
  // done len+SIZE+1 cycles after ack (1 cycle for len=0), busy through done.
  task automatic model_grant(input int a, input bit g, input logic [7:0] b, input logic [7:0] l);
    int d;
    exp_ack[a] = g ? 2'b10 : 2'b01;
    d = (l == 8'd0) ? 1 : int'(l) + SIZE + 1;
    for (int k = 0; k < int'(l); k++) begin
      exp_rden[a+k]  = 1'b1;
      exp_addr[a+k]  = 8'((int'(b) + k) % 256);
      exp_fv[a+k+1]  = 1'b1;
    end
    for (int i = 0; i <= d; i++) exp_busy[a+i] = 1'b1;
    exp_done[a+d] = 1'b1;
    exp_did[a+d]  = g;
    idle_from     = a + d + 1;
  endtask

  // One clock: model decides the grant for the coming edge, then outputs are checked.
  task automatic step();
    bit g;
    if (!reset && cyc >= idle_from && req != 2'b00) begin
      g = (req == 2'b11) ? rr : req[1];
      model_grant(cyc + 1, g, g ? base1 : base0, g ? len1 : len0);
      rr = !g;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("outs", {26'd0, ack, rd_en, feed_valid, busy, done},
             {26'd0, exp_ack[cyc], exp_rden[cyc], exp_fv[cyc], exp_busy[cyc], exp_done[cyc]});
    if (exp_rden[cyc]) check_eq("rd_addr", {24'd0, rd_addr}, {24'd0, exp_addr[cyc]});
    if (exp_done[cyc]) begin
      check_eq("done_id", {31'd0, done_id}, {31'd0, exp_did[cyc]});
      $display("burst done: id=%0d cyc=%0d", exp_did[cyc], cyc);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async", {17'd0, ack, rd_en, feed_valid, busy, done, done_id, rd_addr}, 32'd0);
    clear_from(cyc);
    steps(2);
    reset = 1'b0;
    idle_from = cyc;
    rr = 1'b0;
  endtask

  initial begin
    clear_from(0);
    reset = 1'b1;
    req = 2'b00;
    base0 = 8'h00; len0 = 8'h00; base1 = 8'h00; len1 = 8'h00;
    steps(3);
    reset = 1'b0;
    idle_from = cyc;

    // Single burst.
    req = 2'b01; base0 = 8'h10; len0 = 8'd3;
    step(); req = 2'b00; steps(12);

    // Contention from reset, grants alternate.
    async_reset();
    req = 2'b11; base0 = 8'h40; base1 = 8'h80; len0 = 8'd2; len1 = 8'd2;
    steps(40); req = 2'b00; steps(10);

    // Address wrap.
    req = 2'b10; base1 = 8'hFE; len1 = 8'd4;
    step(); req = 2'b00; steps(12);

    // Zero length.
    req = 2'b10; len1 = 8'd0;
    step(); req = 2'b00; steps(5);

    // Reset in the middle of a burst, then a fresh request.
    req = 2'b01; base0 = 8'h20; len0 = 8'd10;
    step(); req = 2'b00; steps(4);
    async_reset();
    req = 2'b01; base0 = 8'h30; len0 = 8'd2;
    step(); req = 2'b00; steps(10);

    // Request and length change while busy.
    req = 2'b01; base0 = 8'h50; len0 = 8'd5;
    step(); req = 2'b00; len0 = 8'd1; base0 = 8'h99; steps(15);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      for (int r = 0; r < 2; r++) begin
        if (!req[r] && $urandom_range(0, 3) == 0) req[r] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        base0 = 8'($urandom);
        len0  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 3) == 0) begin
        base1 = 8'($urandom);
        len1  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      end
      step();
      for (int r = 0; r < 2; r++) begin
        if (exp_ack[cyc][r]) req[r] = 1'($urandom_range(0, 1));
        else if (exp_busy[cyc] && req[r] && $urandom_range(0, 9) == 0) req[r] = 1'b0;
      end
    end
    req = 2'b00;
    steps(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
